// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined carry look-ahead adder/subtractor
//
// Purpose: WIDTH-bit add/subtract built from BLOCK-bit look-ahead groups.
// One group is resolved per pipeline stage and the group carry is
// registered between stages. Throughput is one beat per cycle and latency
// is NGRP cycles.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready = ~out_valid | out_ready)
//   a, b, c_in, sub     operands; sub=0: a+b+c_in, sub=1: a-b-c_in
//   out_valid/out_ready result handshake
//   sum, c_out, ovf     result, carry-out (sub: 1 = no borrow), signed overflow
//
// Optional feature: define CLA_PIPE_SAT_EN to clamp sum to the signed
// extreme on overflow. The clamp is applied in the final stage.
module cla_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int NGRP = WIDTH / BLOCK;

  if ((BLOCK < 1) || (BLOCK > 8) || ((WIDTH % BLOCK) != 0)) begin : g_param_check
    $fatal(1, "cla_pipe_adder: WIDTH must be a multiple of BLOCK, BLOCK in 1..8");
  end

  // One look-ahead group: returns {group_carry_out, sum_bits}.
  // Carry into bit i is the OR over every generator below i (the group
  // carry-in counts as generator 0) ANDed with the propagates between
  // them, so no carry ripples bit to bit inside the group.
  function automatic logic [BLOCK:0] cla_group(
    input logic [BLOCK-1:0] x,
    input logic [BLOCK-1:0] y,
    input logic             ci
  );
    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK:0]   gx;
    logic [BLOCK-1:0] c;
    logic             t;
    logic             grp_g;
    logic             grp_p;
    p  = x ^ y;
    g  = x & y;
    gx = {g, ci};
    for (int i = 0; i < BLOCK; i++) begin
      c[i] = 1'b0;
      for (int j = 0; j <= i; j++) begin
        t = gx[j];
        for (int m = j; m < i; m++) begin
          t = t & p[m];
        end
        c[i] = c[i] | t;
      end
    end
    grp_g = 1'b0;
    for (int j = 1; j <= BLOCK; j++) begin
      t = gx[j];
      for (int m = j; m < BLOCK; m++) begin
        t = t & p[m];
      end
      grp_g = grp_g | t;
    end
    grp_p = &p;
    return {grp_g | (grp_p & ci), p ^ c};
  endfunction

  logic             en;
  logic [WIDTH-1:0] eb;
  logic             ecin;

  always_comb begin
    en   = ~out_valid | out_ready;
    eb   = b ^ {WIDTH{sub}};
    ecin = c_in ^ sub;
  end

  assign in_ready = en;

  for (genvar k = 0; k < NGRP; k++) begin : stg
    // RW: operand bits still unprocessed entering this stage.
    // SW: result bits resolved once this stage has run.
    localparam int RW = WIDTH - k * BLOCK;
    localparam int SW = (k + 1) * BLOCK;

    logic [RW-1:0]  a_i;
    logic [RW-1:0]  eb_i;
    logic           cin_i;
    logic           v_i;
    logic           sa_i;
    logic           seb_i;
    logic [BLOCK:0] grp;
    logic [SW-1:0]  sum_raw;
    logic [SW-1:0]  sum_d;
    logic [SW-1:0]  sum_q;
    logic           c_d;
    logic           c_q;
    logic           v_d;
    logic           v_q;

    if (k == 0) begin : g_src
      always_comb begin
        a_i     = a;
        eb_i    = eb;
        cin_i   = ecin;
        v_i     = in_valid;
        sa_i    = a[WIDTH-1];
        seb_i   = eb[WIDTH-1];
        sum_raw = grp[BLOCK-1:0];
      end
    end else begin : g_src
      always_comb begin
        a_i     = stg[k-1].g_opr.a_q;
        eb_i    = stg[k-1].g_opr.eb_q;
        cin_i   = stg[k-1].c_q;
        v_i     = stg[k-1].v_q;
        sa_i    = stg[k-1].g_opr.sa_q;
        seb_i   = stg[k-1].g_opr.seb_q;
        sum_raw = {grp[BLOCK-1:0], stg[k-1].sum_q};
      end
    end

    always_comb begin
      grp = cla_group(a_i[BLOCK-1:0], eb_i[BLOCK-1:0], cin_i);
      c_d = grp[BLOCK];
      v_d = v_i;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sum_q <= '0;
        c_q   <= 1'b0;
        v_q   <= 1'b0;
      end else if (en) begin
        sum_q <= sum_d;
        c_q   <= c_d;
        v_q   <= v_d;
      end
    end

    // Upper operand slices and sign bits skew along with the partial sum.
    if (k < NGRP - 1) begin : g_opr
      logic [RW-BLOCK-1:0] a_d;
      logic [RW-BLOCK-1:0] a_q;
      logic [RW-BLOCK-1:0] eb_d;
      logic [RW-BLOCK-1:0] eb_q;
      logic                sa_d;
      logic                sa_q;
      logic                seb_d;
      logic                seb_q;

      always_comb begin
        a_d   = a_i[RW-1:BLOCK];
        eb_d  = eb_i[RW-1:BLOCK];
        sa_d  = sa_i;
        seb_d = seb_i;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q   <= '0;
          eb_q  <= '0;
          sa_q  <= 1'b0;
          seb_q <= 1'b0;
        end else if (en) begin
          a_q   <= a_d;
          eb_q  <= eb_d;
          sa_q  <= sa_d;
          seb_q <= seb_d;
        end
      end
    end

    if (k == NGRP - 1) begin : g_fin
      logic ovf_d;
      logic ovf_q;

      always_comb begin
        ovf_d = (sa_i == seb_i) && (sum_raw[SW-1] != sa_i);
        sum_d = sum_raw;
`ifdef CLA_PIPE_SAT_EN
        if (ovf_d) begin
          sum_d = sa_i ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
        end
`endif
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= ovf_d;
        end
      end
    end else begin : g_pass
      always_comb begin
        sum_d = sum_raw;
      end
    end
  end

  assign out_valid = stg[NGRP-1].v_q;
  assign sum       = stg[NGRP-1].sum_q;
  assign c_out     = stg[NGRP-1].c_q;
  assign ovf       = stg[NGRP-1].g_fin.ovf_q;

endmodule
